// File: rtl/ex_alu_div_pkg.sv
// Shared op codes, result classes and divider state encoding for the EX stage.
package ex_alu_div_pkg;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_alu_div_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed fix-up on the way out.
module div_iter
  import ex_alu_div_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready
);

  localparam int CNT_W = $clog2(DIV_STEPS) + 1;

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [63:0]      acc, acc_n;     // {remainder, quotient/dividend shift}
  logic [31:0]      dvs, dvs_n;
  logic             neg_q, neg_q_n, neg_r, neg_r_n;

  logic [32:0] partial, diff;
  logic        ge;
  logic [31:0] step_rem, abs1, abs2;

  assign abs1     = (signed_div && opdata1[31]) ? neg32(opdata1) : opdata1;
  assign abs2     = (signed_div && opdata2[31]) ? neg32(opdata2) : opdata2;
  assign partial  = acc[63:31];
  assign diff     = partial - {1'b0, dvs};
  assign ge       = partial >= {1'b0, dvs};
  assign step_rem = 32'(ge ? diff : partial);

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no latch is inferred.
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    dvs_n   = dvs;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    if (annul) begin
      state_n = DIV_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          if (opdata2 == 32'd0) begin
            state_n = DIV_DONE;
            acc_n   = {opdata1, 32'hFFFF_FFFF};
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            acc_n   = {32'd0, abs1};
            dvs_n   = abs2;
            neg_q_n = signed_div & (opdata1[31] ^ opdata2[31]);
            neg_r_n = signed_div & opdata1[31];
          end
        end
        DIV_ON: begin
          acc_n = {step_rem, acc[30:0], ge};
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_STEPS - 1)) state_n = DIV_DONE;
        end
        DIV_DONE: state_n = DIV_IDLE;
        default:  state_n = DIV_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the datapath is reset as well, so result reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      acc   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      dvs   <= dvs_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
    end
  end

  assign result = {neg_r ? neg32(acc[63:32]) : acc[63:32],
                   neg_q ? neg32(acc[31:0])  : acc[31:0]};
  assign ready  = (state == DIV_DONE);

endmodule

// File: rtl/ex_alu_div.sv
// EX stage: combinational ALU, HI/LO registers and the stall request for iterative divides.
module ex_alu_div
  import ex_alu_div_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq
);

  logic [31:0] hi, lo, alu_res;
  logic [63:0] div_result;
  logic        div_ready, is_div, signed_div;

  assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign signed_div = (aluop_i == EXE_DIV_OP);

  div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_div(signed_div),
    .annul     (flush),
    .opdata1   (reg1_i),
    .opdata2   (reg2_i),
    .result    (div_result),
    .ready     (div_ready)
  );

  // Held divide commits on the edge leaving DONE, which is also when ID-EX advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (is_div && div_ready) begin
        hi <= div_result[63:32];
        lo <= div_result[31:0];
      end else if (aluop_i == EXE_MTHI_OP) begin
        hi <= reg1_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        lo <= reg1_i;
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (alusel_i)
      EXE_RES_NOP: alu_res = '0;
      EXE_RES_LOGIC:
        case (aluop_i)
          EXE_OR_OP:  alu_res = reg1_i | reg2_i;
          EXE_AND_OP: alu_res = reg1_i & reg2_i;
          EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
          EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
          default:    alu_res = '0;
        endcase
      EXE_RES_SHIFT:
        case (aluop_i)
          EXE_SLL_OP: alu_res = reg1_i << reg2_i[4:0];
          EXE_SRL_OP: alu_res = reg1_i >> reg2_i[4:0];
          EXE_SRA_OP: alu_res = $signed(reg1_i) >>> reg2_i[4:0];
          default:    alu_res = '0;
        endcase
      EXE_RES_MOVE:
        case (aluop_i)
          EXE_MFHI_OP: alu_res = hi;
          EXE_MFLO_OP: alu_res = lo;
          default:     alu_res = '0;
        endcase
      EXE_RES_ARITH:
        case (aluop_i)
          EXE_ADDU_OP: alu_res = reg1_i + reg2_i;
          EXE_SUBU_OP: alu_res = reg1_i - reg2_i;
          EXE_SLT_OP:  alu_res = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
          EXE_SLTU_OP: alu_res = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
          default:     alu_res = '0;
        endcase
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wd_o    = wd_i;
    wreg_o  = wreg_i & ~is_div;
    wdata_o = alu_res;
    if (!rst) begin
      wd_o    = NOP_REG_ADDR;
      wreg_o  = 1'b0;
      wdata_o = '0;
    end
  end

  assign stallreq = rst & is_div & ~div_ready;

endmodule
